// File: rtl/mag_sched.sv
// mag_sched: two-requester magnitude engine computing floor(sqrt(x*x + y*y)).
// Requesters A and B share one squarer and one bit-serial restoring square
// root; a single result is in flight at a time and is held in OUT until the
// consumer accepts it.
`timescale 1ns/1ps
module mag_sched #(
  parameter int unsigned RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [7:0] a_x,
  input  logic [7:0] a_y,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_x,
  input  logic [7:0] b_y,
  output logic       b_ready,
  output logic       r_valid,
  input  logic       r_ready,
  output logic [8:0] r_mag,
  output logic       r_id,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SQR, ROOT, OUT} state_t;

  state_t      state, state_nx;

  logic        last_b;   // 1 = B was served most recently
  logic [7:0]  x_r, y_r;
  logic        id_r;
  logic [17:0] sum_sh;   // sum padded to 9 bit-pairs, consumed MSB pair first
  logic [9:0]  rem_r;
  logic [7:0]  q_r;
  logic [3:0]  cnt;

  logic        a_take, b_take;
  logic [16:0] sq_sum;
  logic [11:0] rem_sh, trial;
  logic        ge;
  logic [9:0]  rem_nx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (a_take || b_take) state_nx = SQR;
      SQR:  state_nx = ROOT;
      ROOT: if (cnt == 4'd8) state_nx = OUT;
      OUT:  if (r_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: grants only in IDLE, tie resolved by round-robin or fixed A
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state == IDLE) begin
      if (a_valid && b_valid) begin
        if (RR_EN != 0 && !last_b) b_ready = 1'b1;
        else                       a_ready = 1'b1;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
    busy    = (state != IDLE);
    r_valid = (state == OUT);
  end

  // Handshake qualifiers and one restoring-root step
  always_comb begin
    a_take = a_valid && a_ready;
    b_take = b_valid && b_ready;
    sq_sum = 17'(x_r) * 17'(x_r) + 17'(y_r) * 17'(y_r);
    rem_sh = {rem_r, sum_sh[17:16]};
    trial  = {2'b00, q_r, 2'b01};
    ge     = (rem_sh >= trial);
    // Remainder never exceeds 2*root (<= 720), so 10 bits hold it exactly.
    if (ge) rem_nx = 10'(rem_sh - trial);
    else    rem_nx = rem_sh[9:0];
  end

  // Datapath: operand capture, squaring, root iteration, result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
      x_r    <= '0;
      y_r    <= '0;
      id_r   <= 1'b0;
      sum_sh <= '0;
      rem_r  <= '0;
      q_r    <= '0;
      cnt    <= '0;
      r_mag  <= '0;
      r_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_take || b_take) begin
            x_r    <= b_take ? b_x : a_x;
            y_r    <= b_take ? b_y : a_y;
            id_r   <= b_take;
            last_b <= b_take;
          end
        end
        SQR: begin
          sum_sh <= {1'b0, sq_sum};
          rem_r  <= '0;
          q_r    <= '0;
          cnt    <= '0;
        end
        ROOT: begin
          sum_sh <= {sum_sh[15:0], 2'b00};
          rem_r  <= rem_nx;
          // Root fits 8 bits until the final step, which lands in r_mag.
          q_r    <= {q_r[6:0], ge};
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd8) begin
            r_mag <= {q_r, ge};
            r_id  <= id_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_sched.sv
// Bench for mag_sched: scoreboard of expected magnitudes pushed at each
// accept and popped at each result handshake, plus scenario tasks.
`timescale 1ns/1ps
module tb_mag_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, r_ready = 1'b0;
  logic [7:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;

  logic       a_ready, b_ready, r_valid, r_id, busy;
  logic [8:0] r_mag;
  logic       fp_a_ready, fp_b_ready, fp_r_valid, fp_r_id, fp_busy;
  logic [8:0] fp_r_mag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_results = 0;

  typedef struct {int mag; int id; int acc;} exp_t;
  exp_t sb[$];
  exp_t e_new, e_old;
  logic prev_rv = 1'b0;

  mag_sched #(.RR_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_ready(a_ready),
    .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_ready(b_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_mag(r_mag), .r_id(r_id),
    .busy(busy)
  );

  mag_sched #(.RR_EN(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_ready(fp_a_ready),
    .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_ready(fp_b_ready),
    .r_valid(fp_r_valid), .r_ready(r_ready), .r_mag(fp_r_mag), .r_id(fp_r_id),
    .busy(fp_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int isqrt(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ready || b_ready) begin
        checks++;
        if (a_ready && b_ready) begin
          errors++;
          $display("FAIL one_hot_ready a_ready=%0b b_ready=%0b required at most one high", a_ready, b_ready);
        end
      end
      if ((a_valid && a_ready) || (b_valid && b_ready)) begin
        e_new.id  = (b_valid && b_ready) ? 1 : 0;
        e_new.mag = (e_new.id == 1) ? isqrt(int'(b_x) * int'(b_x) + int'(b_y) * int'(b_y))
                                    : isqrt(int'(a_x) * int'(a_x) + int'(a_y) * int'(a_y));
        e_new.acc = cyc + 1;
        sb.push_back(e_new);
      end
      if (r_valid && !prev_rv) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result r_valid=1 r_mag=%0d required no result pending", r_mag);
        end else if (cyc - sb[0].acc != 10) begin
          errors++;
          $display("FAIL latency got %0d edges required 10", cyc - sb[0].acc);
        end
      end
      if (r_valid && r_ready && sb.size() != 0) begin
        e_old = sb.pop_front();
        n_results++;
        checks++;
        if (r_mag !== 9'(e_old.mag) || r_id !== 1'(e_old.id)) begin
          errors++;
          $display("FAIL sb_result r_mag=%0d r_id=%0b required r_mag=%0d r_id=%0d",
                   r_mag, r_id, e_old.mag, e_old.id);
        end
      end
      prev_rv = r_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  // Stimulus helper: present one request and hold it until accepted
  task automatic send(input bit is_b, input logic [7:0] x, input logic [7:0] y);
    bit got = 0;
    @(posedge clk); #1;
    if (is_b) begin b_x = x; b_y = y; b_valid = 1'b1; end
    else      begin a_x = x; a_y = y; a_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((is_b && b_ready) || (!is_b && a_ready)) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout ready=0 required ready within 40 cycles");
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && !r_valid) begin done = 1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%0b required 0 within 40 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || r_mag !== 9'd0 || r_id !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs r_valid=%0b r_mag=%0d r_id=%0b busy=%0b required all 0",
               r_valid, r_mag, r_id, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int acc;
    bit seen = 0;
    r_ready = 1'b1;
    a_x = 8'd3; a_y = 8'd4; a_valid = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_idle_grant a_ready=%0b b_ready=%0b required 1 0", a_ready, b_ready);
    end
    @(posedge clk); #1;
    acc = cyc;
    a_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_accept busy=%0b a_ready=%0b required 1 0", busy, a_ready);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_valid) begin seen = 1; break; end
    end
    checks++;
    if (!seen || cyc - acc != 10 || r_mag !== 9'd5 || r_id !== 1'b0) begin
      errors++;
      $display("FAIL single_result seen=%0b edges=%0d r_mag=%0d r_id=%0b required 1 10 5 0",
               seen, cyc - acc, r_mag, r_id);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || r_valid !== 1'b0 || r_mag !== 9'd5) begin
      errors++;
      $display("FAIL after_handshake busy=%0b r_valid=%0b r_mag=%0d required 0 0 5", busy, r_valid, r_mag);
    end
  endtask

  task automatic test_b_corners();
    r_ready = 1'b1;
    send(1'b1, 8'd255, 8'd255);
    wait_idle();
    checks++;
    if (r_mag !== 9'd360 || r_id !== 1'b1) begin
      errors++;
      $display("FAIL b_max r_mag=%0d r_id=%0b required 360 1", r_mag, r_id);
    end
    send(1'b1, 8'd0, 8'd0);
    wait_idle();
    checks++;
    if (r_mag !== 9'd0 || r_id !== 1'b1) begin
      errors++;
      $display("FAIL b_zero r_mag=%0d r_id=%0b required 0 1", r_mag, r_id);
    end
  endtask

  task automatic test_arbitration();
    int rr_ids[$];
    int fp_ids[$];
    int acc = 0;
    bit fp_b_seen = 0;
    bit fp_mag_bad = 0;
    r_ready = 1'b1;
    a_x = 8'd1; a_y = 8'd1; b_x = 8'd2; b_y = 8'd2;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (r_valid && r_ready) rr_ids.push_back(int'(r_id));
      if (fp_r_valid && r_ready) begin
        fp_ids.push_back(int'(fp_r_id));
        if (fp_r_mag !== 9'd1) fp_mag_bad = 1;
      end
      if (fp_b_ready) fp_b_seen = 1;
      if ((a_valid && a_ready) || (b_valid && b_ready)) acc++;
      if (acc == 3 && a_valid) begin
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
      end
      if (rr_ids.size() == 3 && fp_ids.size() == 3) break;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++;
    if (rr_ids.size() != 3 || rr_ids[0] != 0 || rr_ids[1] != 1 || rr_ids[2] != 0) begin
      errors++;
      $display("FAIL rr_order got %p required A,B,A (0,1,0)", rr_ids);
    end
    checks++;
    if (fp_ids.size() != 3 || fp_ids[0] != 0 || fp_ids[1] != 0 || fp_ids[2] != 0 ||
        fp_b_seen || fp_mag_bad) begin
      errors++;
      $display("FAIL fixed_order got %p b_ready_seen=%0b mag_bad=%0b required 0,0,0 and 0 0",
               fp_ids, fp_b_seen, fp_mag_bad);
    end
    wait_idle();
    checks++;
    if (fp_busy !== 1'b0 || fp_a_ready !== 1'b0) begin
      errors++;
      $display("FAIL fixed_idle fp_busy=%0b fp_a_ready=%0b required 0 0", fp_busy, fp_a_ready);
    end
  endtask

  task automatic test_stall();
    bit seen = 0;
    bit bad = 0;
    r_ready = 1'b0;
    send(1'b0, 8'd6, 8'd8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_valid) begin seen = 1; break; end
    end
    @(posedge clk); #1;
    a_x = 8'd9; a_y = 8'd9; a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (r_valid !== 1'b1 || r_mag !== 9'd10 || r_id !== 1'b0 || a_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (!seen || bad) begin
      errors++;
      $display("FAIL stall_hold seen=%0b r_valid=%0b r_mag=%0d a_ready=%0b required 1 1 10 0",
               seen, r_valid, r_mag, a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    r_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_abort();
    bit bad = 0;
    r_ready = 1'b1;
    send(1'b0, 8'd7, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre busy=%0b r_valid=%0b required 1 0", busy, r_valid);
    end
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (r_valid !== 1'b0 || busy !== 1'b0 || r_mag !== 9'd0 || r_id !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs r_valid=%0b busy=%0b r_mag=%0d r_id=%0b required all 0",
               r_valid, busy, r_mag, r_id);
    end
    repeat (12) begin
      @(negedge clk);
      if (r_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_no_valid r_valid seen high required 0");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b0, 8'd5, 8'd12);
    wait_idle();
    checks++;
    if (r_mag !== 9'd13 || r_id !== 1'b0) begin
      errors++;
      $display("FAIL post_abort r_mag=%0d r_id=%0b required 13 0", r_mag, r_id);
    end
  endtask

  task automatic test_random();
    logic [7:0] cx[4] = '{8'd255, 8'd0, 8'd1, 8'd128};
    logic [7:0] cy[4] = '{8'd0, 8'd255, 8'd0, 8'd127};
    int n0;
    int total;
    r_ready = 1'b1;
    n0 = n_results;
    total = 4 + 1500;
    for (int k = 0; k < 4; k++) send(k[0], cx[k], cy[k]);
    for (int k = 0; k < 1500; k++)
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_idle();
    checks++;
    if (n_results - n0 != total || sb.size() != 0) begin
      errors++;
      $display("FAIL random_count results=%0d pending=%0d required %0d 0",
               n_results - n0, sb.size(), total);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_b_corners();
    test_reset();
    test_arbitration();
    test_stall();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
